fetch_unit: RTL

- Instruction-fetch stage of the SimpleRISC core. Upstream of the decode stage that holds the immediate unit and the branch-target adder.
- Owns the PC, issues word requests to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs.
- Presents instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch target or flush) from downstream: discards wrong-path buffered and in-flight instructions, then restarts fetch at the target.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_buf.sv | 86 ++++++++
 rtl/fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared constants and helpers for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buf
// Purpose  : Circular buffer of {pc, instr, filled}; entries are allocated at
//            request time and filled in order as responses return.
// Revision : 1.0
// ============================================================================
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_en,
  input  logic [31:0]        alloc_pc,
  input  logic               fill_en,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               pop_en,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   pending,
  output logic               head_valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [31:0]        head_pc
);

  logic [31:0]        r_pc    [DEPTH];
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [DEPTH-1:0]   r_filled;
  logic [PTR_W-1:0]   r_alloc_ptr;
  logic [PTR_W-1:0]   r_fill_ptr;
  logic [PTR_W-1:0]   r_head_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_pending   <= '0;
      r_filled    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (flush) begin
      // Everything still held is wrong-path; restart the ring from slot 0.
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_pending   <= '0;
      r_filled    <= '0;
    end else begin
      if (alloc_en) begin
        r_pc[r_alloc_ptr]     <= alloc_pc;
        r_filled[r_alloc_ptr] <= 1'b0;
        r_alloc_ptr           <= r_alloc_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        r_filled[r_head_ptr] <= 1'b0;
        r_head_ptr           <= r_head_ptr + PTR_W'(1);
      end
      if (fill_en) begin
        r_instr[r_fill_ptr]  <= fill_instr;
        r_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + PTR_W'(1);
      end
      r_count   <= r_count + CNT_W'(alloc_en) - CNT_W'(pop_en);
      r_pending <= r_pending + CNT_W'(alloc_en) - CNT_W'(fill_en);
    end
  end

  assign count      = r_count;
  assign pending    = r_pending;
  assign head_valid = (r_count != '0) && r_filled[r_head_ptr];
  assign head_instr = r_instr[r_head_ptr];
  assign head_pc    = r_pc[r_head_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage: PC, memory request issue, redirect and
//            wrong-path response dropping, buffered handoff to decode.
// Revision : 1.0
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc
);

  localparam int CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  logic             r_active;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_drop;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_pending;
  logic             w_req_fire;
  logic             w_rsp_drop;
  logic             w_fill;
  logic             w_pop;

  // r_active keeps the request line low until the first edge after reset.
  assign imem_req_valid = r_active && !redirect_valid && (w_count < CNT_W'(DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_pop          = if_valid && if_ready;

  // Old-path responses arrive first, so any pending drop claims this one.
  assign w_rsp_drop = imem_rsp_valid &&
                      ((r_drop != '0) || (redirect_valid && (w_pending != '0)));
  assign w_fill     = imem_rsp_valid && !redirect_valid &&
                      (r_drop == '0) && (w_pending != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_pc     <= RESET_PC;
      r_drop   <= '0;
    end else begin
      r_active <= 1'b1;
      if (redirect_valid) begin
        r_pc <= align_pc(redirect_pc);
      end else if (w_req_fire) begin
        r_pc <= r_pc + PC_STEP;
      end
      r_drop <= r_drop + (redirect_valid ? w_pending : '0) - CNT_W'(w_rsp_drop);
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (w_req_fire),
    .alloc_pc   (r_pc),
    .fill_en    (w_fill),
    .fill_instr (imem_rsp_data),
    .pop_en     (w_pop),
    .flush      (redirect_valid),
    .count      (w_count),
    .pending    (w_pending),
    .head_valid (if_valid),
    .head_instr (if_instr),
    .head_pc    (if_pc)
  );

  a_rsp_expected : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((r_drop != '0) || (w_pending != '0)));

endmodule
`default_nettype wire
